issue_queue: RTL

- Parametrised in-order instruction buffer between Decode and Issue in the superscalar core.
- Generalises the fixed two-lane decode-to-issue handoff to ISSUE_WIDTH lanes and DEPTH entries.
- Accepts up to ISSUE_WIDTH decoded instruction packets per cycle and presents the oldest ISSUE_WIDTH entries to issue logic.
- Supports partial dequeue (issue logic takes 0..ISSUE_WIDTH per cycle), branch-mispredict flush, and a sticky protocol-error flag.

---
 rtl/issue_queue.sv | 116 +++++++++++
 1 files changed

// File: rtl/issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : issue_queue
// Brief    : In-order multi-lane buffer between Decode and Issue with
//            partial dequeue, flush and a sticky protocol-error flag.
// Revision : 1.0 - initial release
// ============================================================================
module issue_queue #(
  parameter int ENTRY_WIDTH = 64,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8,
  parameter int PTR_W       = $clog2(DEPTH),
  parameter int CNT_W       = $clog2(ISSUE_WIDTH) + 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [ISSUE_WIDTH-1:0]             enq_valid,
  input  logic [ISSUE_WIDTH*ENTRY_WIDTH-1:0] enq_data,
  output logic                               enq_ready,
  output logic [ISSUE_WIDTH-1:0]             deq_valid,
  output logic [ISSUE_WIDTH*ENTRY_WIDTH-1:0] deq_data,
  input  logic [CNT_W-1:0]                   deq_take,
  input  logic                               flush,
  output logic [PTR_W:0]                     count,
  output logic                               empty,
  output logic                               full,
  output logic                               err
);

  localparam int c_cw = PTR_W + 1;

  logic [ENTRY_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [c_cw-1:0]        r_count;
  logic                   r_err;

  logic [CNT_W-1:0]       w_offset [ISSUE_WIDTH];
  logic [CNT_W-1:0]       w_n_enq;
  logic [CNT_W-1:0]       w_n_enq_eff;
  logic [CNT_W-1:0]       w_take_lim;
  logic [c_cw-1:0]        w_take_ext;
  logic [c_cw-1:0]        w_n_deq;
  logic                   w_enq_req;
  logic                   w_enq_ok;
  logic                   w_viol;

  assign enq_ready = (r_count <= c_cw'(DEPTH - ISSUE_WIDTH));
  assign empty     = (r_count == '0);
  assign full      = (r_count == c_cw'(DEPTH));
  assign count     = r_count;
  assign err       = r_err;

  // Each valid lane lands at tail plus the number of valid lanes below it.
  always_comb begin
    w_n_enq = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      w_offset[i] = w_n_enq;
      if (enq_valid[i]) begin
        w_n_enq = w_n_enq + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_enq_req   = |enq_valid;
    w_enq_ok    = w_enq_req && enq_ready;
    w_n_enq_eff = w_enq_ok ? w_n_enq : '0;
    w_take_lim  = (deq_take > CNT_W'(ISSUE_WIDTH)) ? CNT_W'(ISSUE_WIDTH) : deq_take;
    w_take_ext  = c_cw'(w_take_lim);
    w_n_deq     = (w_take_ext > r_count) ? r_count : w_take_ext;
    w_viol      = (w_enq_req && !enq_ready)
                || (deq_take > CNT_W'(ISSUE_WIDTH))
                || (c_cw'(deq_take) > r_count);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_n_deq);
      r_tail  <= r_tail + PTR_W'(w_n_enq_eff);
      r_count <= r_count + c_cw'(w_n_enq_eff) - w_n_deq;
      if (w_viol) begin
        r_err <= 1'b1;
      end
    end
  end

  // Storage is deliberately left unreset; empty lanes are masked on output.
  always_ff @(posedge clk) begin
    if (!flush && w_enq_ok) begin
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        if (enq_valid[i]) begin
          r_mem[r_tail + PTR_W'(w_offset[i])] <= enq_data[i*ENTRY_WIDTH +: ENTRY_WIDTH];
        end
      end
    end
  end

  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_lane
    logic [PTR_W-1:0] w_rd_ptr;
    assign w_rd_ptr     = r_head + PTR_W'(i);
    assign deq_valid[i] = (r_count > c_cw'(i));
    assign deq_data[i*ENTRY_WIDTH +: ENTRY_WIDTH] = deq_valid[i] ? r_mem[w_rd_ptr] : '0;
  end

endmodule
`default_nettype wire
